// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline and the iterative
// multiply/divide unit. The pipeline is the master, the unit is the slave.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] opdata1_i;
   logic [WIDTH-1:0] opdata2_i;
   logic             annul_i;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             ready_o;
   logic             div_zero_o;
   logic             stall_req_o;

   modport master (
      output start_i, op_i, opdata1_i, opdata2_i, annul_i,
      input  hi_o, lo_o, ready_o, div_zero_o, stall_req_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
      output hi_o, lo_o, ready_o, div_zero_o, stall_req_o
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit. Signed operations run on operand
// magnitudes and the sign is fixed up when the last step completes.
// Multiply: shift-add over WIDTH cycles, {hi,lo} = full product.
// Divide: restoring subtract-shift over WIDTH cycles, hi = remainder, lo = quotient.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   localparam int                   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
   localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH:0]       ZERO_W1  = {(WIDTH+1){1'b0}};
   localparam logic [2*WIDTH-1:0]   ZERO_2W  = {(2*WIDTH){1'b0}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BYZERO = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Two's-complement negation of a single-width value
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation of a double-width value
   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
      neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t             state_r;
   state_t             state_nx_s;
   logic               accept_s;
   logic               div_op_s;
   logic               zero_div_s;
   logic               sgn1_s;
   logic               sgn2_s;
   logic [WIDTH-1:0]   mag1_s;
   logic [WIDTH-1:0]   mag2_s;

   logic [CW-1:0]      cnt_r;
   logic [2*WIDTH-1:0] work_r;
   logic [WIDTH-1:0]   opb_r;
   logic               is_div_r;
   logic               neg_res_r;
   logic               neg_rem_r;

   logic [WIDTH:0]     msum_s;
   logic [WIDTH:0]     trial_s;
   logic [WIDTH:0]     diff_s;
   logic [2*WIDTH-1:0] step_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   res_hi_s;
   logic [WIDTH-1:0]   res_lo_s;

   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               ready_r;
   logic               dz_r;

   // Decode the incoming request: operation class, operand signs and magnitudes
   always_comb begin
      div_op_s   = bus.op_i[1];
      sgn1_s     = ~bus.op_i[0] & bus.opdata1_i[WIDTH-1];
      sgn2_s     = ~bus.op_i[0] & bus.opdata2_i[WIDTH-1];
      zero_div_s = bus.op_i[1] & (bus.opdata2_i == ZERO_W);
      if (sgn1_s) begin
         mag1_s = neg_w(bus.opdata1_i);
      end else begin
         mag1_s = bus.opdata1_i;
      end
      if (sgn2_s) begin
         mag2_s = neg_w(bus.opdata2_i);
      end else begin
         mag2_s = bus.opdata2_i;
      end
   end

   // Next-state logic; acceptance happens only from IDLE
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start_i && !bus.annul_i) begin
               accept_s = 1'b1;
               if (zero_div_s) begin
                  state_nx_s = BYZERO;
               end else begin
                  state_nx_s = RUN;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         BYZERO: begin
            if (bus.annul_i) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         RUN: begin
            if (bus.annul_i) begin
               state_nx_s = IDLE;
            end else if (cnt_r == CNT_LAST) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (bus.start_i) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // One radix-2 step: shift-add for multiply, restoring subtract-shift for divide
   always_comb begin
      msum_s  = {1'b0, work_r[2*WIDTH-1:WIDTH]} + (work_r[0] ? {1'b0, opb_r} : ZERO_W1);
      trial_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
      diff_s  = trial_s - {1'b0, opb_r};
      step_s  = ZERO_2W;
      if (is_div_r) begin
         if (!diff_s[WIDTH]) begin
            step_s = {diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
         end else begin
            step_s = {trial_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_s = {msum_s, work_r[WIDTH-1:1]};
      end
   end

   // Sign fix-up applied to the value produced by the final step
   always_comb begin
      prod_s   = neg_res_r ? neg_2w(step_s) : step_s;
      res_hi_s = ZERO_W;
      res_lo_s = ZERO_W;
      if (is_div_r) begin
         res_lo_s = neg_res_r ? neg_w(step_s[WIDTH-1:0]) : step_s[WIDTH-1:0];
         res_hi_s = neg_rem_r ? neg_w(step_s[2*WIDTH-1:WIDTH]) : step_s[2*WIDTH-1:WIDTH];
      end else begin
         res_hi_s = prod_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
      end
   end

   // Datapath: capture operands on acceptance, then iterate while running
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= CNT_ZERO;
         work_r    <= ZERO_2W;
         opb_r     <= ZERO_W;
         is_div_r  <= 1'b0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
      end else if (accept_s) begin
         cnt_r     <= CNT_ZERO;
         is_div_r  <= div_op_s;
         neg_res_r <= sgn1_s ^ sgn2_s;
         neg_rem_r <= sgn1_s;
         if (div_op_s) begin
            work_r <= {ZERO_W, mag1_s};
            opb_r  <= mag2_s;
         end else begin
            work_r <= {ZERO_W, mag2_s};
            opb_r  <= mag1_s;
         end
      end else if ((state_r == RUN) && !bus.annul_i) begin
         work_r <= step_s;
         cnt_r  <= cnt_r + CNT_ONE;
      end else begin
         work_r <= work_r;
         cnt_r  <= cnt_r;
      end
   end

   // Result registers: loaded on entry to DONE, held in DONE, cleared elsewhere
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r    <= ZERO_W;
         lo_r    <= ZERO_W;
         ready_r <= 1'b0;
         dz_r    <= 1'b0;
      end else if ((state_r == RUN) && (state_nx_s == DONE)) begin
         hi_r    <= res_hi_s;
         lo_r    <= res_lo_s;
         ready_r <= 1'b1;
         dz_r    <= 1'b0;
      end else if ((state_r == BYZERO) && (state_nx_s == DONE)) begin
         hi_r    <= ZERO_W;
         lo_r    <= ZERO_W;
         ready_r <= 1'b1;
         dz_r    <= 1'b1;
      end else if (state_nx_s == DONE) begin
         hi_r    <= hi_r;
         lo_r    <= lo_r;
         ready_r <= ready_r;
         dz_r    <= dz_r;
      end else begin
         hi_r    <= ZERO_W;
         lo_r    <= ZERO_W;
         ready_r <= 1'b0;
         dz_r    <= 1'b0;
      end
   end

   assign bus.hi_o        = hi_r;
   assign bus.lo_o        = lo_r;
   assign bus.ready_o     = ready_r;
   assign bus.div_zero_o  = dz_r;
   // The stall must reach the pipeline in the same cycle it asks, so it stays combinational
   assign bus.stall_req_o = bus.start_i & ~bus.annul_i & (state_r != DONE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: randomized and directed operations on a 32-bit unit
// checked every cycle against an arithmetic reference, plus a 16-bit unit
// checked at completion.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(32)) bus ();
   muldiv_unit_if #(.WIDTH(16)) bus16 ();

   muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   muldiv_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic for a w-bit unit, using 64-bit integers
   function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo, output logic dz);
      logic [63:0] m, ua, ub, up;
      longint      sa, sb, sp, sq, sr;
      m  = (64'd1 << w) - 64'd1;
      ua = {32'd0, a} & m;
      ub = {32'd0, b} & m;
      sa = a[w-1] ? longint'(ua) - (longint'(1) <<< w) : longint'(ua);
      sb = b[w-1] ? longint'(ub) - (longint'(1) <<< w) : longint'(ub);
      hi = 32'd0;
      lo = 32'd0;
      dz = 1'b0;
      case (op)
         2'b00: begin sp = sa * sb; up = sp; end
         2'b01: up = ua * ub;
         2'b10: begin
            if (sb == 0) dz = 1'b1;
            else begin sq = sa / sb; sr = sa % sb; up = sr; hi = 32'(up & m); up = sq; lo = 32'(up & m); end
         end
         default: begin
            if (ub == 64'd0) dz = 1'b1;
            else begin up = ua % ub; hi = 32'(up & m); up = ua / ub; lo = 32'(up & m); end
         end
      endcase
      if (!op[1]) begin
         lo = 32'(up & m);
         hi = 32'((up >> w) & m);
      end
   endfunction

   // Cycle-level expectation for the 32-bit unit
   bit          m_valid = 1'b0;
   bit          m_busy  = 1'b0;
   bit          m_done  = 1'b0;
   int          m_left  = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi, p_lo;
   logic        m_dz = 1'b0, p_dz;

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0;
      end else if (m_done) begin
         if (!bus.start_i) begin m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_dz = 1'b0; end
      end else if (m_busy) begin
         if (bus.annul_i) m_busy = 1'b0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end
         end
      end else if (bus.start_i && !bus.annul_i) begin
         model(32, bus.op_i, bus.opdata1_i, bus.opdata2_i, p_hi, p_lo, p_dz);
         m_busy = 1'b1;
         m_left = p_dz ? 1 : 32;
      end
      m_valid = 1'b1;
   end

   // Compare every output of the 32-bit unit against the expectation
   always @(negedge clk) begin
      if (m_valid) begin
         chk("ready", bus.ready_o, m_done);
         chk("hi", bus.hi_o, m_hi);
         chk("lo", bus.lo_o, m_lo);
         chk("div_zero", bus.div_zero_o, m_dz);
         chk("stall", bus.stall_req_o, bus.start_i & ~bus.annul_i & ~m_done);
      end
   end

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: pick = 32'h0000_0000;
         1: pick = 32'h0000_0001;
         2: pick = 32'hFFFF_FFFF;
         3: pick = 32'h8000_0000;
         4: pick = 32'h7FFF_FFFF;
         5: pick = $urandom_range(0, 255);
         default: pick = $urandom();
      endcase
   endfunction

   // Runs one 32-bit operation; starts and ends just after a rising edge
   task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit lit, input logic [31:0] ehi,
                        input logic [31:0] elo);
      int edges, lat;
      bit seen;
      logic [31:0] rhi, rlo;
      logic rdz;
      model(32, op, a, b, rhi, rlo, rdz);
      lat = rdz ? 2 : 33;
      bus.start_i = 1'b1; bus.op_i = op; bus.opdata1_i = a; bus.opdata2_i = b; bus.annul_i = 1'b0;
      edges = 0; seen = 1'b0;
      while (!seen && edges < 60) begin
         @(posedge clk); #1; edges++;
         if (bus.ready_o) seen = 1'b1;
         else begin bus.opdata1_i = $urandom(); bus.opdata2_i = $urandom(); end
      end
      chk("ready_timeout", seen, 1'b1);
      chk("latency", edges, lat);
      if (lit) begin
         chk("lit_hi", bus.hi_o, ehi);
         chk("lit_lo", bus.lo_o, elo);
         chk("lit_dz", bus.div_zero_o, rdz);
      end
      for (int i = 0; i < hold; i++) begin
         bus.annul_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("done_held_hi", bus.hi_o, rhi);
      end
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_drop", bus.ready_o, 1'b0);
   endtask

   task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit lit, input logic [15:0] ehi, input logic [15:0] elo);
      int edges, lat;
      bit seen;
      logic [31:0] rhi, rlo;
      logic rdz;
      model(16, op, {16'd0, a}, {16'd0, b}, rhi, rlo, rdz);
      lat = rdz ? 2 : 17;
      bus16.start_i = 1'b1; bus16.op_i = op; bus16.opdata1_i = a; bus16.opdata2_i = b;
      edges = 0; seen = 1'b0;
      while (!seen && edges < 40) begin
         @(posedge clk); #1; edges++;
         if (bus16.ready_o) seen = 1'b1;
         else begin bus16.opdata1_i = 16'($urandom()); bus16.opdata2_i = 16'($urandom()); end
      end
      chk("w16_timeout", seen, 1'b1);
      chk("w16_latency", edges, lat);
      chk("w16_hi", bus16.hi_o, rhi[15:0]);
      chk("w16_lo", bus16.lo_o, rlo[15:0]);
      chk("w16_dz", bus16.div_zero_o, rdz);
      if (lit) begin
         chk("w16_lit_hi", bus16.hi_o, ehi);
         chk("w16_lit_lo", bus16.lo_o, elo);
      end
      bus16.start_i = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] th, tl;
      logic        tz;
      bit          saw_ready;
      rst = 1'b1;
      bus.start_i = 1'b0; bus.op_i = 2'b00; bus.opdata1_i = 32'd0; bus.opdata2_i = 32'd0; bus.annul_i = 1'b0;
      bus16.start_i = 1'b0; bus16.op_i = 2'b00; bus16.opdata1_i = 16'd0; bus16.opdata2_i = 16'd0; bus16.annul_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.ready_o, 1'b0);
      chk("rst_hi", bus.hi_o, 32'd0);
      chk("rst_lo", bus.lo_o, 32'd0);
      chk("rst_dz", bus.div_zero_o, 1'b0);
      bus.start_i = 1'b1;
      #1;
      chk("rst_stall", bus.stall_req_o, 1'b1);
      bus.start_i = 1'b0;
      rst = 1'b0;

      // Pin the reference against hand-computed values
      model(32, 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, th, tl, tz);
      chk("model_mult", {th, tl}, 64'hFFFF_FFFF_FFFF_FFF1);
      model(32, 2'b11, 32'd100, 32'd7, th, tl, tz);
      chk("model_divu", {th, tl}, {32'd2, 32'd14});
      model(32, 2'b10, 32'hFFFF_FFF9, 32'd2, th, tl, tz);
      chk("model_div", {th, tl}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      model(32, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, th, tl, tz);
      chk("model_divwrap", {th, tl}, {32'd0, 32'h8000_0000});
      model(16, 2'b00, 32'h0000_8000, 32'h0000_8000, th, tl, tz);
      chk("model_w16", {th, tl}, {32'h4000, 32'h0000});

      @(posedge clk); #1;
      run32(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run32(2'b11, 32'd100, 32'd7, 1, 1'b1, 32'd2, 32'd14);
      run32(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'd0, 32'h8000_0000);
      run32(2'b10, 32'd1234, 32'd0, 3, 1'b1, 32'd0, 32'd0);
      run32(2'b11, 32'hDEAD_BEEF, 32'd0, 1, 1'b1, 32'd0, 32'd0);

      // Annul at iteration 10, then an unsigned multiply
      bus.start_i = 1'b1; bus.op_i = 2'b00; bus.opdata1_i = 32'd77; bus.opdata2_i = 32'd99;
      repeat (11) @(posedge clk);
      #1;
      bus.annul_i = 1'b1;
      @(posedge clk); #1;
      bus.annul_i = 1'b0; bus.start_i = 1'b0;
      saw_ready = 1'b0;
      repeat (36) begin @(posedge clk); #1; if (bus.ready_o) saw_ready = 1'b1; end
      chk("annul_no_ready", saw_ready, 1'b0);
      run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);

      // Start with annul held in IDLE is not accepted
      bus.start_i = 1'b1; bus.annul_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bus.start_i = 1'b0; bus.annul_i = 1'b0;
      @(posedge clk); #1;

      // Reset mid-run with start still requested
      bus.start_i = 1'b1; bus.op_i = 2'b01; bus.opdata1_i = 32'h1234_5678; bus.opdata2_i = 32'h9ABC_DEF0;
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready", bus.ready_o, 1'b0);
      chk("midrst_hi", bus.hi_o, 32'd0);
      chk("midrst_lo", bus.lo_o, 32'd0);
      rst = 1'b0; bus.start_i = 1'b0;
      saw_ready = 1'b0;
      repeat (36) begin @(posedge clk); #1; if (bus.ready_o) saw_ready = 1'b1; end
      chk("midrst_no_ready", saw_ready, 1'b0);

      // 16-bit unit
      run16(2'b00, 16'h8000, 16'h8000, 1'b1, 16'h4000, 16'h0000);
      run16(2'b10, 16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h8000);
      run16(2'b11, 16'd50000, 16'd0, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         run16(2'($urandom_range(0, 3)), 16'($urandom()), 16'($urandom()), 1'b0, 16'd0, 16'd0);
      end

      // Randomized operations on the 32-bit unit
      for (int i = 0; i < 40; i++) begin
         run32(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 3), 1'b0, 32'd0, 32'd0);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand width in bits (even, >=8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_i  input  1  request to run a multiply/divide.
REQ-005 SHALL have port op_i  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port opdata1_i  input  WIDTH  multiplicand/dividend.
REQ-007 SHALL have port opdata2_i  input  WIDTH  multiplier/divisor.
REQ-008 SHALL have port annul_i  input  1  cancel the in-flight operation (branch flush/exception).
REQ-009 SHALL have port hi_o  output  WIDTH  product upper half / remainder.
REQ-010 SHALL have port lo_o  output  WIDTH  product lower half / quotient.
REQ-011 SHALL have port ready_o  output  1  hi_o/lo_o valid.
REQ-012 SHALL have port div_zero_o  output  1  completed operation was divide with opdata2_i==0.
REQ-013 SHALL have port stall_req_o  output  1  pipeline stall request while the unit is working.

Function
REQ-014 SHALL implement FSM states IDLE, BYZERO, RUN, DONE.
REQ-015 IDLE: start_i=1 and annul_i=0 SHALL latch op_i, opdata1_i and opdata2_i at that edge; divide with opdata2_i==0 -> BYZERO, otherwise -> RUN with iteration counter 0; start_i=0 or annul_i=1 SHALL hold IDLE.
REQ-016 Operands SHALL be sampled only at acceptance; later input changes SHALL NOT affect the result.
REQ-017 RUN SHALL last exactly WIDTH cycles, one radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide; counter WIDTH-1 -> DONE.
REQ-018 BYZERO SHALL last one cycle -> DONE, with hi_o=lo_o=0 and div_zero_o=1 in DONE.
REQ-019 Signed ops SHALL iterate on magnitudes; product negated when sign1^sign2; quotient negated when sign1^sign2; remainder takes dividend sign.
REQ-020 DIV of most-negative value by -1 SHALL give lo_o=most-negative value, hi_o=0 (wrap, no flag).
REQ-021 Multiply SHALL give full 2*WIDTH product as {hi_o,lo_o}; divide SHALL give hi_o=remainder, lo_o=quotient.
REQ-022 DONE: ready_o=1, hi_o/lo_o/div_zero_o held stable; start_i=1 holds DONE; start_i=0 -> IDLE next edge.
REQ-023 Outside DONE, ready_o, div_zero_o, hi_o and lo_o SHALL be 0.
REQ-024 Latency: ready_o SHALL first be 1 in the cycle after the (WIDTH+1)th edge following acceptance, or after the 2nd edge for divide-by-zero.
REQ-025 stall_req_o SHALL be combinational: 1 when start_i=1, annul_i=0 and state is IDLE, BYZERO or RUN; 0 otherwise.
REQ-026 annul_i=1 in BYZERO or RUN SHALL force IDLE at the next edge with no ready_o pulse; annul_i in DONE SHALL be ignored.
REQ-027 No new operation SHALL be accepted outside IDLE; start_i is level-held by the pipeline until ready_o.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, counter 0 and internal datapath registers 0, from any state including mid-RUN.
REQ-029 During and after reset, until the next acceptance: ready_o=0, div_zero_o=0, hi_o=lo_o=0, stall_req_o follows REQ-025.
REQ-030 Reset SHALL take priority over start_i and annul_i.

Verification
REQ-031 W=32, MULT 0xFFFFFFFD*0x00000005 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1, ready_o after 33 edges, stall_req_o=1 until then.
REQ-032 DIVU 100/7 -> lo_o=0x0000000E, hi_o=0x00000002; DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-033 DIV x/0 -> ready_o after 2 edges, div_zero_o=1, hi_o=lo_o=0; DONE held while start_i=1, IDLE one edge after start_i drops.
REQ-034 annul_i pulsed at RUN iteration 10 -> IDLE next edge, ready_o never 1; next MULTU 0xFFFFFFFF*0xFFFFFFFF -> {hi_o,lo_o}=0xFFFFFFFE_00000001.
REQ-035 rst mid-RUN -> all outputs 0 next cycle; operands changed during RUN do not alter result; WIDTH=16 MULT 0x8000*0x8000 -> hi_o=0x4000, lo_o=0x0000 after 17 edges.
